// File: rtl/lcd_bus_monitor.sv
// Passive HD44780-style text LCD bus reader: decodes bus writes into a shadow 2x16
// character buffer, mirroring the DDRAM address counter and display-control state.
module lcd_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  LINE2_BASE  = 7'h40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   tlcd_d,
  input  logic         tlcd_e,
  input  logic         tlcd_rs,
  input  logic         tlcd_rw,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic [6:0]   cursor_addr,
  output logic         display_on,
  output logic [7:0]   last_cmd,
  output logic         cmd_strobe,
  output logic         data_strobe,
  output logic         offscreen_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StExec    = 2'd2;

  localparam logic [127:0] Blank = {16{8'h20}};

  // Bus bits packed {e, rs, rw, d[7:0]} so every bit sees identical delay.
  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic sync_e, sync_rs, sync_rw;
  logic [7:0] sync_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {tlcd_e, tlcd_rs, tlcd_rw, tlcd_d}};
    end
  end

  assign sync_e  = sync_q[SYNC_STAGES-1][10];
  assign sync_rs = sync_q[SYNC_STAGES-1][9];
  assign sync_rw = sync_q[SYNC_STAGES-1][8];
  assign sync_d  = sync_q[SYNC_STAGES-1][7:0];

  logic [1:0]   state_q, state_d;
  logic         rs_q, rs_d, rw_q, rw_d;
  logic [7:0]   dat_q, dat_d;
  logic [127:0] line1_q, line1_d, line2_q, line2_d;
  logic [6:0]   cursor_q, cursor_d;
  logic         inc_q, inc_d, cgram_q, cgram_d, disp_q, disp_d;
  logic [7:0]   last_cmd_q, last_cmd_d;
  logic         cmd_stb_q, cmd_stb_d, data_stb_q, data_stb_d;
  logic         off_err_q, off_err_d;
  logic [6:0]   line2_off;

  // Two-line DDRAM map: 0x00..0x27 and 0x40..0x67 form one ring.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      step_addr = 7'h40;
      else if (a == 7'h67) step_addr = 7'h00;
      else                 step_addr = a + 7'd1;
    end else begin
      if (a == 7'h00)      step_addr = 7'h67;
      else if (a == 7'h40) step_addr = 7'h27;
      else                 step_addr = a - 7'd1;
    end
  endfunction

  assign line2_off = cursor_q - LINE2_BASE;

  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    dat_d      = dat_q;
    line1_d    = line1_q;
    line2_d    = line2_q;
    cursor_d   = cursor_q;
    inc_d      = inc_q;
    cgram_d    = cgram_q;
    disp_d     = disp_q;
    last_cmd_d = last_cmd_q;
    cmd_stb_d  = 1'b0;
    data_stb_d = 1'b0;
    off_err_d  = off_err_q;

    case (state_q)
      StIdle, StCapture: begin
        if (sync_e) begin
          state_d = StCapture;
          rs_d    = sync_rs;
          rw_d    = sync_rw;
          dat_d   = sync_d;
        end else if (state_q == StCapture) begin
          // Falling E: commit the transfer so it is visible while in EXEC.
          state_d = StExec;
          if (!rw_q && !rs_q) begin
            last_cmd_d = dat_q;
            cmd_stb_d  = 1'b1;
            casez (dat_q)
              8'b1???_????: begin
                cursor_d = dat_q[6:0];
                cgram_d  = 1'b0;
              end
              8'b01??_????: cgram_d = 1'b1;
              8'b001?_????: ;
              8'b0001_????: if (!dat_q[3]) cursor_d = step_addr(cursor_q, dat_q[2]);
              8'b0000_1???: disp_d = dat_q[2];
              8'b0000_01??: inc_d = dat_q[1];
              8'b0000_001?: begin
                cursor_d = 7'd0;
                cgram_d  = 1'b0;
              end
              8'b0000_0001: begin
                line1_d  = Blank;
                line2_d  = Blank;
                cursor_d = 7'd0;
                inc_d    = 1'b1;
                cgram_d  = 1'b0;
              end
              default: ;
            endcase
          end else if (!rw_q && rs_q) begin
            data_stb_d = 1'b1;
            if (!cgram_q) begin
              if (cursor_q < 7'd16) begin
                for (int c = 0; c < 16; c++) begin
                  if (cursor_q == 7'(c)) line1_d[127-8*c -: 8] = dat_q;
                end
              end else if (line2_off < 7'd16) begin
                for (int c = 0; c < 16; c++) begin
                  if (line2_off == 7'(c)) line2_d[127-8*c -: 8] = dat_q;
                end
              end else begin
                off_err_d = 1'b1;
              end
              cursor_d = step_addr(cursor_q, inc_q);
            end
          end
        end
      end
      StExec:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      dat_q      <= 8'h00;
      line1_q    <= Blank;
      line2_q    <= Blank;
      cursor_q   <= 7'd0;
      inc_q      <= 1'b1;
      cgram_q    <= 1'b0;
      disp_q     <= 1'b0;
      last_cmd_q <= 8'h00;
      cmd_stb_q  <= 1'b0;
      data_stb_q <= 1'b0;
      off_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      dat_q      <= dat_d;
      line1_q    <= line1_d;
      line2_q    <= line2_d;
      cursor_q   <= cursor_d;
      inc_q      <= inc_d;
      cgram_q    <= cgram_d;
      disp_q     <= disp_d;
      last_cmd_q <= last_cmd_d;
      cmd_stb_q  <= cmd_stb_d;
      data_stb_q <= data_stb_d;
      off_err_q  <= off_err_d;
    end
  end

  assign line1         = line1_q;
  assign line2         = line2_q;
  assign cursor_addr   = cursor_q;
  assign display_on    = disp_q;
  assign last_cmd      = last_cmd_q;
  assign cmd_strobe    = cmd_stb_q;
  assign data_strobe   = data_stb_q;
  assign offscreen_err = off_err_q;

endmodule
